shift_sequencer: RTL and testbench

- Multi-cycle shift controller that sequences a 1-bit shift stage to perform full variable-amount shifts: logical left, logical right and arithmetic right.
- Sits beside the ALU. The ALU issues a start with operand, amount and op, then waits for done.
- Trades latency for area: one bit position per cycle instead of a barrel shifter.

---
 rtl/shift_sequencer.sv | 78 +++++++
 tb/tb_shift_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: SLL / SRL / SRA by a variable amount, one bit position per cycle.
// The ALU pulses start, then waits for the one-cycle done pulse that carries the result.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMTW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [AMTW-1:0]  shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] w, w_shift;
    logic [AMTW-1:0]  cnt;
    logic [1:0]       op_q;

    always_comb begin
        w_shift = w;
        case (op_q)
            2'b00:   w_shift = {w[WIDTH-2:0], 1'b0};
            2'b01:   w_shift = {1'b0, w[WIDTH-1:1]};
            default: w_shift = {w[WIDTH-1], w[WIDTH-1:1]};
        endcase
    end

    // A zero amount or the reserved op skips SHIFT, so the counter never wraps.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (shamt == '0 || op == 2'b11) ? FINISH : SHIFT;
            SHIFT:   if (cnt == AMTW'(1)) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            w      <= '0;
            cnt    <= '0;
            op_q   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    w    <= a;
                    cnt  <= shamt;
                    op_q <= op;
                    busy <= (state_nx == SHIFT);
                end
                SHIFT: begin
                    w   <= w_shift;
                    cnt <= cnt - 1'b1;
                end
                FINISH: begin
                    result <= w;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, busy, done;
    logic [1:0]  op;
    logic [31:0] a, result;
    logic [4:0]  shamt;

    int nchk = 0;
    int nfail = 0;

    shift_sequencer #(.WIDTH(32), .AMTW(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a),
        .shamt(shamt), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v, input int s);
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return 32'($signed(v) >>> s);
            default: return v;
        endcase
    endfunction

    // Drive a start now (caller picks the phase), then track the op to its done pulse.
    // pulse_at >= 0 fires an extra start with a = 0 that many cycles into the operation.
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] v,
                       input logic [4:0] s, input int pulse_at);
        int k, bcnt, lat, both;
        bit got;
        lat  = (s == 0 || o == 2'b11) ? 1 : int'(s) + 1;
        start = 1'b1; op = o; a = v; shamt = s;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; shamt = 5'($urandom); op = 2'($urandom);
        k = 0; bcnt = 0; both = 0; got = 0;
        if (busy) bcnt++;
        while (!got && k < 100) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (k == pulse_at) begin start = 1'b1; a = '0; end
            if (busy && done) both++;
            if (done) got = 1;
            else if (busy) bcnt++;
        end
        chk({tag, ".latency"}, k, lat);
        chk({tag, ".result"}, result, model(o, v, int'(s)));
        chk({tag, ".busy_cycles"}, bcnt, (lat == 1) ? 0 : lat);
        chk({tag, ".busy_and_done"}, both, 0);
    endtask

    initial begin
        int dcnt;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; shamt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.result", result, 0);
        @(negedge clk); reset = 1'b0;

        @(negedge clk); run("sra4", 2'b10, 32'h8000_0010, 5'd4, -1);
        chk("sra4.value", result, 32'hF800_0001);
        @(negedge clk); run("sll31", 2'b00, 32'h0000_0001, 5'd31, -1);
        chk("sll31.value", result, 32'h8000_0000);
        @(negedge clk); run("srl31", 2'b01, 32'h8000_0000, 5'd31, -1);
        chk("srl31.value", result, 32'h0000_0001);
        @(negedge clk); run("bypass0", 2'b10, 32'hDEAD_BEEF, 5'd0, -1);
        @(negedge clk); run("bypass_op3", 2'b11, 32'hDEAD_BEEF, 5'd7, -1);
        @(negedge clk); run("sra31_neg", 2'b10, 32'h8000_0000, 5'd31, -1);
        chk("sra31_neg.value", result, 32'hFFFF_FFFF);

        // Ignored start mid-operation, then exactly one done pulse.
        @(negedge clk); run("busy_start", 2'b01, 32'hFFFF_FFFF, 5'd8, 3);
        chk("busy_start.value", result, 32'h00FF_FFFF);
        // Back-to-back: start issued during the done cycle.
        run("b2b", 2'b00, 32'h0000_000F, 5'd2, -1);
        chk("b2b.value", result, 32'h0000_003C);
        dcnt = 0;
        repeat (4) begin @(posedge clk); #1; if (done) dcnt++; end
        chk("b2b.no_extra_done", dcnt, 0);

        // Reset mid-operation abandons the shift.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'hF000_0000; shamt = 5'd20;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midreset.busy", busy, 0);
        chk("midreset.done", done, 0);
        chk("midreset.result", result, 0);
        dcnt = 0;
        repeat (30) begin @(posedge clk); #1; if (done) dcnt++; end
        chk("midreset.no_done", dcnt, 0);
        @(negedge clk); run("after_reset", 2'b10, 32'h8000_0010, 5'd4, -1);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            run($sformatf("rnd%0d", i), 2'($urandom), $urandom, 5'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
